// File: rtl/enc_pkg.sv
// Shared types and widths for the encounter handler and its event FIFO.
package enc_pkg;

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned LIVES_W = 2;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ENC1 = 2'd1,
    ENC2 = 2'd2,
    ENC3 = 2'd3
  } enc_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OFFER,
    ST_WINDOW,
    ST_JUDGE,
    ST_OVER
  } state_t;

endpackage

// File: rtl/enc_event_fifo.sv
// Small synchronous FIFO of encounter types; full/empty come from wrap-bit pointers.
module enc_event_fifo
  import enc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  enc_type_t data_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output enc_type_t head_c_o,
  output logic      full_c_o,
  output logic      empty_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  enc_type_t        mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_c;
  logic             do_pop_c;

  assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c_o = (wr_ptr_q == rd_ptr_q);
  assign do_push_c = push_i && !full_c_o && !flush_i;
  assign do_pop_c  = pop_i && !empty_c_o && !flush_i;
  assign head_c_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/encounter_handler.sv
// Detects new encounters, queues them, offers each to the renderer and judges the response.
// Optional: define ENC_HANDLER_QUICK_BONUS_EN to score +2 for hits in the first quarter of the window.
module encounter_handler
  import enc_pkg::*;
#(
  parameter int unsigned RESPONSE_CYCLES = 50_000_000,
  parameter int unsigned START_LIVES     = 3,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enc1_in,
  input  logic               enc2_in,
  input  logic               enc3_in,
  input  logic               btn_jump,
  input  logic               btn_duck,
  input  logic               btn_dash,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [1:0]         spawn_type,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               overflow
);

  localparam int unsigned      CNT_W    = $clog2(RESPONSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESPONSE_CYCLES - 1);

  logic [2:0]         enc_prev_q;
  logic [2:0]         enc_rise_c;
  enc_type_t          push_type_c;
  logic               push_c;
  logic               pop_c;
  logic               flush_c;
  enc_type_t          head_c;
  logic               full_c;
  logic               empty_c;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  enc_type_t          spawn_type_q, spawn_type_d;
  logic               spawn_valid_q, spawn_valid_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               game_over_q, game_over_d;
  logic               overflow_q, overflow_d;

  logic [2:0]         btn_c;
  logic [2:0]         want_btn_c;
  logic               quick_c;
  logic [1:0]         score_inc_c;
  logic [SCORE_W:0]   score_sum_c;

  // Rising edges with fixed priority enc1 > enc2 > enc3; losers are discarded.
  assign enc_rise_c = {enc3_in, enc2_in, enc1_in} & ~enc_prev_q;

  always_comb begin
    push_type_c = NONE;
    if (enc_rise_c[0])      push_type_c = ENC1;
    else if (enc_rise_c[1]) push_type_c = ENC2;
    else if (enc_rise_c[2]) push_type_c = ENC3;
  end

  assign flush_c = (state_q == ST_OVER);
  assign push_c  = (push_type_c != NONE) && !flush_c;

  enc_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .push_i    (push_c),
    .data_i    (push_type_c),
    .pop_i     (pop_c),
    .flush_i   (flush_c),
    .head_c_o  (head_c),
    .full_c_o  (full_c),
    .empty_c_o (empty_c)
  );

  assign btn_c = {btn_dash, btn_duck, btn_jump};

  always_comb begin
    want_btn_c = 3'b000;
    case (spawn_type_q)
      ENC1:    want_btn_c = 3'b001;
      ENC2:    want_btn_c = 3'b010;
      ENC3:    want_btn_c = 3'b100;
      default: want_btn_c = 3'b000;
    endcase
  end

`ifdef ENC_HANDLER_QUICK_BONUS_EN
  localparam logic [CNT_W-1:0] QUICK_TH = CNT_W'(3 * RESPONSE_CYCLES / 4);
  assign quick_c = (cnt_q >= QUICK_TH);
`else
  assign quick_c = 1'b0;
`endif

  assign score_inc_c = quick_c ? 2'd2 : 2'd1;
  assign score_sum_c = {1'b0, score_q} + (SCORE_W+1)'(score_inc_c);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    spawn_type_d = spawn_type_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    score_d      = score_q;
    lives_d      = lives_q;
    pop_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c        = 1'b1;
          spawn_type_d = head_c;
          state_d      = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (spawn_valid_q && spawn_ready) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        // Verdict is registered on entry to JUDGE, so the pulse is visible during JUDGE.
        if ((btn_c != 3'b000) && (btn_c == want_btn_c)) begin
          hit_d        = 1'b1;
          score_d      = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
          spawn_type_d = NONE;
          state_d      = ST_JUDGE;
        end else if ((btn_c != 3'b000) || (cnt_q == '0)) begin
          miss_d       = 1'b1;
          lives_d      = lives_q - LIVES_W'(1);
          spawn_type_d = NONE;
          state_d      = ST_JUDGE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_JUDGE: state_d = (lives_q == '0) ? ST_OVER : ST_IDLE;
      ST_OVER:  state_d = ST_OVER;
      default:  state_d = ST_IDLE;
    endcase

    spawn_valid_d = (state_d == ST_OFFER);
    game_over_d   = (state_d == ST_OVER);
    overflow_d    = overflow_q | (push_c & full_c);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enc_prev_q    <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      spawn_type_q  <= NONE;
      spawn_valid_q <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      score_q       <= '0;
      lives_q       <= LIVES_W'(START_LIVES);
      game_over_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      enc_prev_q    <= {enc3_in, enc2_in, enc1_in};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      spawn_type_q  <= spawn_type_d;
      spawn_valid_q <= spawn_valid_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      game_over_q   <= game_over_d;
      overflow_q    <= overflow_d;
    end
  end

  assign spawn_valid = spawn_valid_q;
  assign spawn_type  = spawn_type_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_encounter_handler.sv
// Self-checking bench for encounter_handler; expected spawn types flow through a scoreboard queue.
module tb_encounter_handler;
  import enc_pkg::*;

  localparam int unsigned R      = 16;
  localparam int unsigned LIVES0 = 3;
  localparam int unsigned DEPTH  = 4;
`ifdef ENC_HANDLER_QUICK_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enc1_in, enc2_in, enc3_in;
  logic        btn_jump, btn_duck, btn_dash;
  logic        spawn_ready;
  logic        spawn_valid;
  logic [1:0]  spawn_type;
  logic        hit, miss;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        game_over;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q[$];
  int          exp_score;
  int          exp_lives;

  always #5 clock = ~clock;

  encounter_handler #(
    .RESPONSE_CYCLES (R),
    .START_LIVES     (LIVES0),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enc1_in     (enc1_in),
    .enc2_in     (enc2_in),
    .enc3_in     (enc3_in),
    .btn_jump    (btn_jump),
    .btn_duck    (btn_duck),
    .btn_dash    (btn_dash),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_type  (spawn_type),
    .hit         (hit),
    .miss        (miss),
    .score       (score),
    .lives       (lives),
    .game_over   (game_over),
    .overflow    (overflow)
  );

  task automatic rise(input logic [2:0] m);
    {enc3_in, enc2_in, enc1_in} = m;
    @(negedge clock);
    {enc3_in, enc2_in, enc1_in} = 3'b000;
    @(negedge clock);
  endtask

  // Wait for an offer, handshake, respond with btns sampled k edges after the handshake (btns=0: time out).
  task automatic do_encounter(input logic [2:0] btns, input int k);
    int         n;
    int         inc;
    logic [1:0] et;
    logic [2:0] want;
    logic       exp_hit;
    logic       early;
    spawn_ready = 1'b1;
    n = 0;
    while (spawn_valid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (spawn_valid !== 1'b1) begin
      $display("FAIL spawn_wait: spawn_valid=%b required 1 within 100 cycles", spawn_valid);
      n_fail++;
      return;
    end
    et = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
    n_checks++;
    if (spawn_type !== et) begin
      $display("FAIL spawn_type: got %0d expected %0d", spawn_type, et);
      n_fail++;
    end
    case (et)
      2'd1:    want = 3'b001;
      2'd2:    want = 3'b010;
      2'd3:    want = 3'b100;
      default: want = 3'b000;
    endcase
    exp_hit = (btns != 3'b000) && (btns == want);
    inc = (BONUS && (int'(R) - k) >= int'((3 * R) / 4)) ? 2 : 1;
    @(posedge clock);
    early = 1'b0;
    @(negedge clock);
    if (btns != 3'b000) begin
      repeat (k - 1) begin
        early |= hit | miss;
        @(negedge clock);
      end
      early |= hit | miss;
      {btn_dash, btn_duck, btn_jump} = btns;
      @(negedge clock);
      {btn_dash, btn_duck, btn_jump} = 3'b000;
    end else begin
      repeat (R - 1) begin
        early |= hit | miss;
        @(negedge clock);
      end
      early |= hit | miss;
      @(negedge clock);
    end
    n_checks++;
    if (early !== 1'b0) begin
      $display("FAIL early_pulse: hit/miss seen before response, got %b expected 0", early);
      n_fail++;
    end
    n_checks++;
    if (hit !== exp_hit) begin
      $display("FAIL hit_pulse: got %b expected %b", hit, exp_hit);
      n_fail++;
    end
    n_checks++;
    if (miss !== !exp_hit) begin
      $display("FAIL miss_pulse: got %b expected %b", miss, !exp_hit);
      n_fail++;
    end
    if (exp_hit) exp_score = (exp_score + inc > 65535) ? 65535 : exp_score + inc;
    else if (exp_lives > 0) exp_lives--;
    n_checks++;
    if (score !== 16'(exp_score)) begin
      $display("FAIL score: got %0d expected %0d", score, exp_score);
      n_fail++;
    end
    n_checks++;
    if (lives !== 2'(exp_lives)) begin
      $display("FAIL lives: got %0d expected %0d", lives, exp_lives);
      n_fail++;
    end
    n_checks++;
    if (spawn_type !== 2'd0) begin
      $display("FAIL type_clear: got %0d expected 0", spawn_type);
      n_fail++;
    end
    @(negedge clock);
    n_checks++;
    if ((hit | miss) !== 1'b0) begin
      $display("FAIL pulse_width: hit=%b miss=%b expected both 0", hit, miss);
      n_fail++;
    end
    n_checks++;
    if (spawn_valid !== 1'b0) begin
      $display("FAIL judge_gap: spawn_valid=%b expected 0", spawn_valid);
      n_fail++;
    end
    n_checks++;
    if (game_over !== (exp_lives == 0)) begin
      $display("FAIL game_over: got %b expected %b", game_over, (exp_lives == 0));
      n_fail++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {enc3_in, enc2_in, enc1_in} = 3'b000;
    {btn_dash, btn_duck, btn_jump} = 3'b000;
    spawn_ready = 1'b0;
    exp_q.delete();
    exp_score = 0;
    exp_lives = LIVES0;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if ({spawn_valid, spawn_type, hit, miss} !== 5'b0) begin
      $display("FAIL reset_ctrl: valid/type/hit/miss=%b expected 00000", {spawn_valid, spawn_type, hit, miss});
      n_fail++;
    end
    n_checks++;
    if (score !== 16'd0) begin
      $display("FAIL reset_score: got %0d expected 0", score);
      n_fail++;
    end
    n_checks++;
    if (lives !== 2'(LIVES0)) begin
      $display("FAIL reset_lives: got %0d expected %0d", lives, LIVES0);
      n_fail++;
    end
    n_checks++;
    if ({game_over, overflow} !== 2'b00) begin
      $display("FAIL reset_flags: game_over/overflow=%b expected 00", {game_over, overflow});
      n_fail++;
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (spawn_valid !== 1'b0) begin
      $display("FAIL idle_after_reset: spawn_valid=%b expected 0", spawn_valid);
      n_fail++;
    end
  endtask

  task automatic test_hit();
    spawn_ready = 1'b1;
    exp_q.push_back(2'd2);
    enc2_in = 1'b1;
    @(negedge clock);
    n_checks++;
    if (spawn_valid !== 1'b0) begin
      $display("FAIL spawn_early: spawn_valid=%b expected 0 one cycle after rise", spawn_valid);
      n_fail++;
    end
    enc2_in = 1'b0;
    @(negedge clock);
    n_checks++;
    if (spawn_valid !== 1'b1) begin
      $display("FAIL spawn_latency: spawn_valid=%b expected 1 two cycles after rise", spawn_valid);
      n_fail++;
    end
    do_encounter(3'b010, 10);
  endtask

  task automatic test_timeout();
    exp_q.push_back(2'd1);
    rise(3'b001);
    do_encounter(3'b000, 0);
  endtask

  task automatic test_priority();
    logic seen;
    exp_q.push_back(2'd1);
    rise(3'b101);
    do_encounter(3'b001, 5);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      seen |= spawn_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      $display("FAIL priority_drop: spawn_valid seen=%b expected 0", seen);
      n_fail++;
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      $display("FAIL priority_ovf: overflow=%b expected 0", overflow);
      n_fail++;
    end
  endtask

  task automatic test_multi_button();
    exp_q.push_back(2'd3);
    rise(3'b100);
    do_encounter(3'b101, 3);
  endtask

  task automatic test_overflow();
    logic seen;
    spawn_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(2'((i % 3) + 1));
      rise(3'(1 << (i % 3)));
      n_checks++;
      if (overflow !== (i == 5)) begin
        $display("FAIL overflow_%0d: got %b expected %b", i, overflow, (i == 5));
        n_fail++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      do_encounter(3'(1 << (i % 3)), 2);
      if (i < 4) begin
        @(negedge clock);
        n_checks++;
        if (spawn_valid !== 1'b1) begin
          $display("FAIL back_to_back_%0d: spawn_valid=%b expected 1", i, spawn_valid);
          n_fail++;
        end
      end
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      seen |= spawn_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      $display("FAIL dropped_entry: spawn_valid seen=%b expected 0", seen);
      n_fail++;
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      $display("FAIL overflow_sticky: got %b expected 1", overflow);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_window();
    logic seen;
    spawn_ready = 1'b1;
    exp_q.push_back(2'd2);
    rise(3'b010);
    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    btn_duck = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({spawn_valid, spawn_type, hit, miss} !== 5'b0) begin
      $display("FAIL midreset_ctrl: valid/type/hit/miss=%b expected 00000", {spawn_valid, spawn_type, hit, miss});
      n_fail++;
    end
    n_checks++;
    if ({score, lives, overflow} !== {16'd0, 2'(LIVES0), 1'b0}) begin
      $display("FAIL midreset_state: score=%0d lives=%0d overflow=%b expected 0/%0d/0", score, lives, overflow, LIVES0);
      n_fail++;
    end
    exp_q.delete();
    exp_score = 0;
    exp_lives = LIVES0;
    @(negedge clock);
    btn_duck = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      seen |= hit | miss | spawn_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      $display("FAIL midreset_pulse: hit/miss/valid seen=%b expected 0", seen);
      n_fail++;
    end
    exp_q.push_back(2'd2);
    rise(3'b010);
    do_encounter(3'b010, 1);
  endtask

  task automatic test_game_over();
    logic seen;
    for (int i = 0; i < int'(LIVES0); i++) begin
      exp_q.push_back(2'd1);
      rise(3'b001);
      do_encounter(3'b000, 0);
    end
    rise(3'b010);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      seen |= spawn_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      $display("FAIL over_absorb: spawn_valid seen=%b expected 0", seen);
      n_fail++;
    end
    n_checks++;
    if ({game_over, lives} !== {1'b1, 2'd0}) begin
      $display("FAIL over_state: game_over=%b lives=%0d expected 1/0", game_over, lives);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_timeout();
    test_priority();
    test_multi_button();
    test_overflow();
    test_reset_mid_window();
    test_game_over();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
